// File: rtl/pc_gen.sv
// Program-counter generator: sequential step, jump/branch/trap/eret redirects.
// Define PC_ALIGN_CHECK_EN to trap misaligned redirect targets.
module pc_gen #(
    parameter int unsigned    N         = 32,
    parameter logic [N-1:0]   RESET_VEC = 'h00400000,
    parameter logic [N-1:0]   EXC_VEC   = 'h00400004,
    parameter int unsigned    STEP      = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         jmp,
    input  logic [N-1:0] jmp_target,
    input  logic         br_taken,
    input  logic [N-1:0] br_target,
    input  logic         exc,
    input  logic         eret,
    output logic [N-1:0] pc,
    output logic [N-1:0] pc_plus,
    output logic [N-1:0] epc,
    output logic         pc_valid,
    output logic         misalign
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [N-1:0] LOW_MASK   = N'(STEP - 1);
    localparam logic [N-1:0] ALIGN_MASK = ~LOW_MASK;

    state_t       state_q, state_d;
    logic [N-1:0] pc_q, pc_d;
    logic [N-1:0] epc_q, epc_d;
    logic         mis_q, mis_d;
    logic         redir;
    logic [N-1:0] tgt;

    assign pc       = pc_q;
    assign epc      = epc_q;
    assign pc_plus  = pc_q + N'(STEP);
    assign pc_valid = (state_q == RUN);
    assign misalign = mis_q;

    // Winning redirect among the ena-gated requests: eret > branch > jump
    always_comb begin
        redir = eret | br_taken | jmp;
        tgt   = jmp_target;
        if (eret)
            tgt = epc_q;
        else if (br_taken)
            tgt = br_target;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        mis_d   = 1'b0;
        unique case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (exc) begin
                    epc_d   = pc_q;
                    pc_d    = EXC_VEC;
                    state_d = FLUSH;
                end else if (ena) begin
`ifdef PC_ALIGN_CHECK_EN
                    if (redir && ((tgt & LOW_MASK) != '0)) begin
                        epc_d   = pc_q;
                        pc_d    = EXC_VEC;
                        state_d = FLUSH;
                        mis_d   = 1'b1;
                    end else if (redir) begin
                        pc_d = tgt & ALIGN_MASK;
                    end else begin
                        pc_d = pc_plus;
                    end
`else
                    if (redir)
                        pc_d = tgt & ALIGN_MASK;
                    else
                        pc_d = pc_plus;
`endif
                end
            end
            FLUSH: state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_VEC;
            epc_q   <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            mis_q   <= mis_d;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed plan plus randomized traffic
// compared each cycle against a behavioural PC model.
module tb_pc_gen;

    localparam logic [31:0] RV   = 32'h00400000;
    localparam logic [31:0] EV   = 32'h00400004;
    localparam int          STEP = 4;

    logic        clk = 1'b0;
    logic        rst, ena, jmp, br_taken, exc, eret;
    logic [31:0] jmp_target, br_target;
    logic [31:0] pc, pc_plus, epc;
    logic        pc_valid, misalign;

    pc_gen dut (
        .clk(clk), .rst(rst), .ena(ena),
        .jmp(jmp), .jmp_target(jmp_target),
        .br_taken(br_taken), .br_target(br_target),
        .exc(exc), .eret(eret),
        .pc(pc), .pc_plus(pc_plus), .epc(epc),
        .pc_valid(pc_valid), .misalign(misalign)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_pc, m_epc;
    logic        m_valid, m_mis;
    int          m_bubbles;

`ifdef PC_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_trap(input bit mis);
        m_epc     = m_pc;
        m_pc      = EV;
        m_valid   = 1'b0;
        m_bubbles = 1;
        m_mis     = mis;
    endtask

    // What one rising edge must do, from the architectural rules
    task automatic model_edge();
        logic [31:0] t;
        m_mis = 1'b0;
        if (rst) begin
            m_pc = RV; m_epc = 0; m_valid = 1'b0; m_bubbles = 1;
        end else if (m_bubbles > 0) begin
            m_bubbles--;
            m_valid = 1'b1;
        end else if (exc) begin
            model_trap(1'b0);
        end else if (ena) begin
            if (eret || br_taken || jmp) begin
                t = eret ? m_epc : (br_taken ? br_target : jmp_target);
                if (ALIGN_CHK && (t % STEP) != 0)
                    model_trap(1'b1);
                else
                    m_pc = t - (t % STEP);
            end else begin
                m_pc = m_pc + STEP;
            end
        end
    endtask

    task automatic compare_all();
        chk("pc", pc, m_pc);
        chk("pc_plus", pc_plus, m_pc + STEP);
        chk("epc", epc, m_epc);
        chk("pc_valid", {31'd0, pc_valid}, {31'd0, m_valid});
        chk("misalign", {31'd0, misalign}, {31'd0, m_mis});
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic drive(input bit r, input bit e, input bit x, input bit er,
                         input bit b, input logic [31:0] bt,
                         input bit j, input logic [31:0] jt);
        rst = r; ena = e; exc = x; eret = er;
        br_taken = b; br_target = bt; jmp = j; jmp_target = jt;
    endtask

    initial begin
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        cycle();
        chk("lit_reset_pc", pc, 32'h00400000);
        chk("lit_reset_valid", {31'd0, pc_valid}, 32'd0);
        chk("lit_reset_epc", epc, 32'd0);

        drive(0, 1, 0, 0, 0, 0, 0, 0);
        cycle();
        chk("lit_boot_pc", pc, 32'h00400000);
        chk("lit_boot_valid", {31'd0, pc_valid}, 32'd1);
        cycle();
        chk("lit_seq1", pc, 32'h00400004);
        chk("lit_plus", pc_plus, 32'h00400008);
        cycle();
        chk("lit_seq2", pc, 32'h00400008);
        cycle(); cycle();

        ena = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("lit_stall", pc, 32'h00400010);
        end
        ena = 1;
        cycle(); cycle(); cycle(); cycle();
        chk("lit_pc20", pc, 32'h00400020);

        drive(0, 1, 1, 0, 1, 32'h00400100, 1, 32'h00400200);
        cycle();
        chk("lit_trap_pc", pc, 32'h00400004);
        chk("lit_trap_epc", epc, 32'h00400020);
        chk("lit_trap_valid", {31'd0, pc_valid}, 32'd0);
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        cycle();
        chk("lit_flush_pc", pc, 32'h00400004);
        eret = 1;
        cycle();
        chk("lit_eret", pc, 32'h00400020);

        drive(0, 1, 0, 0, 1, 32'h00400100, 1, 32'h00400200);
        cycle();
        chk("lit_br_wins", pc, 32'h00400100);
        ena = 0;
        cycle();
        chk("lit_br_stalled", pc, 32'h00400100);
        drive(0, 0, 1, 0, 0, 0, 0, 0);
        cycle();
        chk("lit_exc_noena", pc, 32'h00400004);
        chk("lit_exc_noena_epc", epc, 32'h00400100);

        drive(1, 1, 1, 1, 1, 32'h00400100, 1, 32'h00400200);
        cycle();
        chk("lit_midrst_pc", pc, 32'h00400000);
        chk("lit_midrst_epc", epc, 32'd0);
        chk("lit_midrst_valid", {31'd0, pc_valid}, 32'd0);
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        cycle();

        drive(0, 1, 0, 0, 0, 0, 1, 32'hFFFFFFFC);
        cycle();
        chk("lit_jmp_top", pc, 32'hFFFFFFFC);
        jmp = 0;
        cycle();
        chk("lit_wrap", pc, 32'h00000000);

        drive(0, 1, 0, 0, 0, 0, 1, 32'h00400102);
        cycle();
`ifdef PC_ALIGN_CHECK_EN
        chk("lit_mis_pc", pc, 32'h00400004);
        chk("lit_mis_epc", epc, 32'h00000000);
        chk("lit_mis_pulse", {31'd0, misalign}, 32'd1);
        jmp = 0;
        cycle();
        chk("lit_mis_end", {31'd0, misalign}, 32'd0);
`else
        chk("lit_mask_pc", pc, 32'h00400100);
        chk("lit_mask_mis", {31'd0, misalign}, 32'd0);
        jmp = 0;
        cycle();
`endif

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] bt, jt;
            bt = $urandom;
            jt = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFF0 | ($urandom & 32'hF))
                                             : $urandom;
            if ($urandom_range(0, 3) != 0) bt = bt & 32'hFFFFFFFC;
            if ($urandom_range(0, 3) != 0) jt = jt & 32'hFFFFFFFC;
            drive($urandom_range(0, 63) == 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 5) == 0, bt,
                  $urandom_range(0, 5) == 0, jt);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator: the next generation of the plain enable-load PC register.
- Holds the architectural PC and computes next-PC internally: sequential increment, or redirect by jump, branch, exception or exception-return.
- Captures the exception PC (EPC) and flags fetch bubbles after reset and after traps.
- Sits at the head of the fetch stage and feeds instruction memory and the branch unit.

Parameters:
N, 32, PC / target width in bits
RESET_VEC, 32'h00400000, PC value loaded on reset
EXC_VEC, 32'h00400004, trap handler entry address
STEP, 4, sequential increment in bytes (power of two, ≥1)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
ena  input  1  advance enable; low = stall (PC held)
jmp  input  1  jump redirect request
jmp_target  input  N  jump target address
br_taken  input  1  taken-branch redirect request
br_target  input  N  branch target address
exc  input  1  exception request
eret  input  1  return from exception
pc  output  N  current PC
pc_plus  output  N  pc + STEP, combinational, modulo 2^N
epc  output  N  captured exception PC
pc_valid  output  1  pc is a real fetch address (low during bubble)
misalign  output  1  one-cycle pulse on misaligned redirect (feature only)

Behaviour:
- Reset: clk and rst exactly as stated above; reset is synchronous and active-high.
  - When rst is high at a rising edge: pc=RESET_VEC, epc=0, pc_valid=0, misalign=0, state=BOOT.
  - rst overrides every other input.
  - rst asserted mid-operation discards any pending redirect.
- States: BOOT, RUN, FLUSH (2-bit register).
- BOOT: one bubble cycle; pc held; all requests ignored; next state RUN, pc_valid=1.
- RUN: next-PC selection, priority highest first:
  1. exc: evaluated regardless of ena. epc<=pc; pc<=EXC_VEC; pc_valid<=0; next state FLUSH.
  2. eret, only when ena=1: pc<=epc; stay in RUN.
  3. br_taken, only when ena=1: pc<=br_target.
  4. jmp, only when ena=1: pc<=jmp_target.
  5. Otherwise, when ena=1: pc<=pc+STEP, wrapping modulo 2^N (e.g. all-ones-minus-3 -> 0 for STEP=4).
  6. ena=0 with no exc: pc, epc and state held. Redirect requests are dropped; the requester holds them until ena=1.
- FLUSH: one bubble cycle; pc held at EXC_VEC; requests ignored, including exc; next state RUN, pc_valid<=1.
- Simultaneous requests:
  - exc together with any other request: exc wins and the others are discarded.
  - br_taken together with jmp: branch wins.
- eret in RUN with no prior exception loads epc (0 after reset). This is legal and not checked.
- Target alignment: the low log2(STEP) bits of jmp_target, br_target and epc are forced to 0 before loading. EXC_VEC and RESET_VEC are used as-is.
- Latency:
  - Every redirect takes effect on pc at the edge where it is sampled.
  - pc_plus follows pc combinationally.
- epc changes only on an accepted exc (or reset).

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - A jmp/br_taken/eret redirect whose target has any nonzero low log2(STEP) bit is not taken.
  - It is treated as an exception instead: epc<=pc, pc<=EXC_VEC, next state FLUSH, pc_valid<=0.
  - misalign is high for exactly the cycle after that edge.
  - An aligned target behaves as the base design.
- Undefined:
  - Low bits are silently masked (base behaviour).
  - misalign is tied to 0.

Test Plan:
- Reset then free-run, ena=1, defaults: pc=00400000 with pc_valid=0 for 1 cycle; then 00400000 valid; then 00400004, 00400008; pc_plus always pc+4.
- Stall and wrap: ena=0 for 3 cycles at pc=00400010, pc held at 00400010. Separately, force pc=FFFFFFFC via jmp; next sequential edge gives pc=00000000.
- Priority: at pc=00400020, assert exc+br_taken(00400100)+jmp(00400200) together → pc=00400004, epc=00400020, pc_valid=0 one cycle; then eret → pc=00400020.
- br_taken(00400100)+jmp(00400200) with ena=1 → pc=00400100. Same request with ena=0 → pc unchanged. exc with ena=0 still traps.
- Mid-op reset: assert rst during FLUSH → pc=00400000, epc=0, state BOOT, pc_valid=0.
- Alignment, jmp to 00400102:
  - Without PC_ALIGN_CHECK_EN: pc=00400100, misalign=0.
  - With it: pc=00400004, epc=old pc, misalign pulses 1 cycle.
